// File: rtl/rv_trace_capture.sv
// Circular trace buffer for the RV32 retirement stream: armed, frozen POST_TRIG
// retirements after a trigger, then drained oldest-first over a valid/ready port.
module rv_trace_capture #(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int DEPTH_LOG2       = 4,
  parameter int POST_TRIG        = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_arm,
  input  logic                        i_trigger,
  input  logic                        i_ret_valid,
  input  logic [IADDR_SPACE_BITS-1:0] i_ret_pc,
  input  logic [31:0]                 i_ret_instr,
  input  logic                        i_ret_reg_write,
  input  logic [31:0]                 i_ret_reg_data,
  output logic [1:0]                  o_state,
  output logic [DEPTH_LOG2:0]         o_count,
  output logic                        o_overflow,
  output logic                        o_rd_valid,
  input  logic                        i_rd_ready,
  output logic [IADDR_SPACE_BITS-1:0] o_rd_pc,
  output logic [31:0]                 o_rd_instr,
  output logic                        o_rd_reg_write,
  output logic [31:0]                 o_rd_data,
  output logic                        o_rd_last
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] POST_LD = DEPTH_LOG2'(POST_TRIG);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  typedef struct packed {
    logic [IADDR_SPACE_BITS-1:0] pc;
    logic [31:0]                 instr;
    logic                        reg_write;
    logic [31:0]                 data;
  } entry_t;

  entry_t                mem [DEPTH];
  entry_t                rd_e;
  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] post_cnt;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  capture;
  logic                  rd_fire;

  // i_arm wins over everything, including a retirement in the same cycle
  assign capture = i_ret_valid & ~i_arm & ((state == S_ARMED) | (state == S_POST));
  assign rd_fire = o_rd_valid & i_rd_ready;
  // Oldest entry trails the write pointer by count; a full buffer wraps to wr_ptr
  assign rd_ptr  = wr_ptr - count[DEPTH_LOG2-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else if (i_arm) begin
      state    <= S_ARMED;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + 1'b1;
      end
      case (state)
        S_ARMED: if (i_trigger) begin
          if (POST_TRIG == 0) state <= S_DONE;
          else begin
            state    <= S_POST;
            post_cnt <= POST_LD;
          end
        end
        S_POST: if (capture) begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == 1) state <= S_DONE;
        end
        S_DONE: if (rd_fire) count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is intentionally not reset; only the pointers define validity
  always_ff @(posedge i_clk) begin
    if (capture)
      mem[wr_ptr] <= '{pc:        i_ret_pc,
                       instr:     i_ret_instr,
                       reg_write: i_ret_reg_write,
                       data:      i_ret_reg_write ? i_ret_reg_data : 32'h0};
  end

  assign rd_e           = mem[rd_ptr];
  assign o_state        = state;
  assign o_count        = count;
  assign o_overflow     = overflow;
  assign o_rd_valid     = (state == S_DONE) && (count != '0);
  assign o_rd_pc        = o_rd_valid ? rd_e.pc : '0;
  assign o_rd_instr     = o_rd_valid ? rd_e.instr : '0;
  assign o_rd_reg_write = o_rd_valid & rd_e.reg_write;
  assign o_rd_data      = o_rd_valid ? rd_e.data : '0;
  assign o_rd_last      = o_rd_valid & (count == 1);

endmodule

// File: tb/tb_rv_trace_capture.sv
// Bench for rv_trace_capture: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (second DUT has POST_TRIG=0).
module tb_rv_trace_capture;

  localparam int AW = 32;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  localparam int PT = 4;

  logic          i_clk = 0, i_reset = 0;
  logic          i_arm = 0, i_trigger = 0, i_ret_valid = 0, i_ret_reg_write = 0, i_rd_ready = 0;
  logic [AW-1:0] i_ret_pc = '0;
  logic [31:0]   i_ret_instr = '0, i_ret_reg_data = '0;

  logic [1:0]    o_state, z_state;
  logic [DL:0]   o_count, z_count;
  logic          o_overflow, o_rd_valid, o_rd_reg_write, o_rd_last;
  logic          z_overflow, z_rd_valid, z_rd_reg_write, z_rd_last;
  logic [AW-1:0] o_rd_pc, z_rd_pc;
  logic [31:0]   o_rd_instr, o_rd_data, z_rd_instr, z_rd_data;

  int tests = 0, fails = 0;

  always #5 i_clk = ~i_clk;

  rv_trace_capture #(.IADDR_SPACE_BITS(AW), .DEPTH_LOG2(DL), .POST_TRIG(PT)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_arm(i_arm), .i_trigger(i_trigger),
    .i_ret_valid(i_ret_valid), .i_ret_pc(i_ret_pc), .i_ret_instr(i_ret_instr),
    .i_ret_reg_write(i_ret_reg_write), .i_ret_reg_data(i_ret_reg_data),
    .o_state(o_state), .o_count(o_count), .o_overflow(o_overflow),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_pc(o_rd_pc),
    .o_rd_instr(o_rd_instr), .o_rd_reg_write(o_rd_reg_write), .o_rd_data(o_rd_data),
    .o_rd_last(o_rd_last));

  rv_trace_capture #(.IADDR_SPACE_BITS(AW), .DEPTH_LOG2(DL), .POST_TRIG(0)) u_dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_arm(i_arm), .i_trigger(i_trigger),
    .i_ret_valid(i_ret_valid), .i_ret_pc(i_ret_pc), .i_ret_instr(i_ret_instr),
    .i_ret_reg_write(i_ret_reg_write), .i_ret_reg_data(i_ret_reg_data),
    .o_state(z_state), .o_count(z_count), .o_overflow(z_overflow),
    .o_rd_valid(z_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_pc(z_rd_pc),
    .o_rd_instr(z_rd_instr), .o_rd_reg_write(z_rd_reg_write), .o_rd_data(z_rd_data),
    .o_rd_last(z_rd_last));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (for u_dut, POST_TRIG=PT) ----------------
  typedef struct {logic [AW-1:0] pc; logic [31:0] instr; logic rw; logic [31:0] data;} ent_t;
  ent_t q[$];
  int   m_state = 0, m_post = 0;
  logic m_ovf = 0;

  function automatic void m_capture();
    ent_t e;
    e.pc = i_ret_pc; e.instr = i_ret_instr; e.rw = i_ret_reg_write;
    e.data = i_ret_reg_write ? i_ret_reg_data : 32'h0;
    if (q.size() == DEPTH) begin
      void'(q.pop_front());
      m_ovf = 1;
    end
    q.push_back(e);
  endfunction

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_state = 0; q.delete(); m_ovf = 0; m_post = 0;
    end else if (i_arm) begin
      m_state = 1; q.delete(); m_ovf = 0; m_post = 0;
    end else begin
      case (m_state)
        1: begin
          if (i_ret_valid) m_capture();
          if (i_trigger) begin
            if (PT > 0) begin m_state = 2; m_post = PT; end
            else m_state = 3;
          end
        end
        2: if (i_ret_valid) begin
          m_capture();
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        3: if (q.size() > 0 && i_rd_ready) void'(q.pop_front());
        default: ;
      endcase
    end
  end

  always @(negedge i_clk) begin
    logic v;
    v = (m_state == 3) && (q.size() > 0);
    chk("state", 64'(o_state), 64'(m_state));
    chk("count", 64'(o_count), 64'(q.size()));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("rd_valid", 64'(o_rd_valid), 64'(v));
    chk("rd_last", 64'(o_rd_last), 64'(v && q.size() == 1));
    chk("rd_pc", 64'(o_rd_pc), v ? 64'(q[0].pc) : 64'h0);
    chk("rd_instr", 64'(o_rd_instr), v ? 64'(q[0].instr) : 64'h0);
    chk("rd_rw", 64'(o_rd_reg_write), v ? 64'(q[0].rw) : 64'h0);
    chk("rd_data", 64'(o_rd_data), v ? 64'(q[0].data) : 64'h0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge i_clk); @(negedge i_clk); #1;
  endtask

  task automatic do_arm(input logic trig = 0);
    i_arm = 1; i_trigger = trig; cyc(); i_arm = 0; i_trigger = 0;
  endtask

  task automatic ret(input logic [31:0] pc, input logic trig = 0);
    i_ret_valid = 1; i_ret_pc = pc; i_ret_instr = 32'h13 | (pc << 8);
    i_ret_reg_write = pc[2]; i_ret_reg_data = pc ^ 32'h5a5a; i_trigger = trig;
    cyc();
    i_ret_valid = 0; i_trigger = 0;
  endtask

  initial begin
    i_reset = 1; #12; i_reset = 0;
    @(negedge i_clk); #1;
    chk("rst_state", 64'(o_state), 0);
    chk("rst_count", 64'(o_count), 0);
    chk("rst_valid", 64'(o_rd_valid), 0);

    // Basic capture
    do_arm();
    chk("arm_state", 64'(o_state), 1);
    ret(32'h100); ret(32'h104); ret(32'h108);
    ret(32'h10C, 1);
    chk("post_state", 64'(o_state), 2);
    for (int i = 0; i < 4; i++) ret(32'h110 + 4*i);
    chk("basic_state", 64'(o_state), 3);
    chk("basic_count", 64'(o_count), 8);
    chk("basic_ovf", 64'(o_overflow), 0);
    i_rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("basic_pc", 64'(o_rd_pc), 64'(32'h100 + 4*i));
      chk("basic_last", 64'(o_rd_last), 64'(i == 7));
      cyc();
    end
    i_rd_ready = 0;
    chk("basic_empty", 64'(o_count), 0);
    chk("basic_nvalid", 64'(o_rd_valid), 0);
    chk("basic_stay", 64'(o_state), 3);

    // Wrap + backpressure
    do_arm();
    for (int i = 0; i < 20; i++) ret(4*i);
    i_trigger = 1; cyc(); i_trigger = 0;
    for (int i = 0; i < 4; i++) ret(32'h50 + 4*i);
    chk("wrap_state", 64'(o_state), 3);
    chk("wrap_count", 64'(o_count), 16);
    chk("wrap_ovf", 64'(o_overflow), 1);
    chk("wrap_first", 64'(o_rd_pc), 32'h20);
    i_rd_ready = 1; cyc();
    chk("bp_pc1", 64'(o_rd_pc), 32'h24);
    i_rd_ready = 0; cyc();
    chk("bp_hold1", 64'(o_rd_pc), 32'h24);
    cyc();
    chk("bp_hold2", 64'(o_rd_pc), 32'h24);
    i_rd_ready = 1; cyc();
    chk("bp_pc2", 64'(o_rd_pc), 32'h28);
    chk("bp_count", 64'(o_count), 14);
    for (int i = 0; i < 14; i++) begin
      chk("wrap_pc", 64'(o_rd_pc), 64'(32'h28 + 4*i));
      chk("wrap_last", 64'(o_rd_last), 64'(i == 13));
      cyc();
    end
    i_rd_ready = 0;
    chk("wrap_empty", 64'(o_count), 0);

    // Data masking on the POST_TRIG=0 instance
    do_arm();
    i_ret_valid = 1; i_ret_pc = 32'h200; i_ret_instr = 32'h00a00093;
    i_ret_reg_write = 1; i_ret_reg_data = 32'hA; cyc();
    i_ret_pc = 32'h204; i_ret_instr = 32'h00112023;
    i_ret_reg_write = 0; i_ret_reg_data = 32'hDEAD; i_trigger = 1; cyc();
    i_ret_valid = 0; i_trigger = 0;
    chk("pt0_state", 64'(z_state), 3);
    chk("pt0_count", 64'(z_count), 2);
    chk("pt0_instr", 64'(z_rd_instr), 32'h00a00093);
    chk("pt0_data0", 64'(z_rd_data), 32'hA);
    chk("pt0_rw0", 64'(z_rd_reg_write), 1);
    i_rd_ready = 1; cyc();
    chk("pt0_data1", 64'(z_rd_data), 32'h0);
    chk("pt0_rw1", 64'(z_rd_reg_write), 0);
    chk("pt0_last", 64'(z_rd_last), 1);
    cyc(); i_rd_ready = 0;
    chk("pt0_empty", 64'(z_rd_valid), 0);

    // Arm/trigger collision
    do_arm(1);
    chk("coll_state", 64'(o_state), 1);
    chk("coll_count", 64'(o_count), 0);
    ret(32'h300, 1);
    chk("coll_trig", 64'(o_state), 2);
    chk("coll_cap", 64'(o_count), 1);

    // Async reset mid-POST
    ret(32'h304);
    chk("mid_post", 64'(o_state), 2);
    @(negedge i_clk); #2;
    i_reset = 1; #1;
    chk("arst_state", 64'(o_state), 0);
    chk("arst_count", 64'(o_count), 0);
    chk("arst_valid", 64'(o_rd_valid), 0);
    cyc();
    i_reset = 0;
    ret(32'h400, 1);
    chk("idle_ignore", 64'(o_state), 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
